i2c_slave: RTL and testbench

I2C target (slave) endpoint that answers a single 7-bit address on a bus driven by an `i2c` master. Oversamples `sclk`/`sda_in` on the system clock and detects START, repeated START and STOP. Handles write transfers, delivering received bytes to a byte-wide output. Handles read transfers, serialising bytes fetched from a byte-wide input. Sits between the serial pins and a register file or FIFO in the device fabric.

---
 rtl/i2c_slave.sv | 231 +++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C target endpoint answering one 7-bit address with byte-wide rx/tx ports.
// Optional I2C_SLAVE_FILTER_EN adds a 3-sample majority filter on both pins.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h2d
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       sda_in,
    output logic       sda_out,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        RX       = 3'd3,
        RX_ACK   = 3'd4,
        TX       = 3'd5,
        TX_ACK   = 3'd6
    } state_t;

    state_t     cur_st, nxt_st;
    logic [1:0] scl_sync, sda_sync;
    logic       scl_f, sda_f, scl_d, sda_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], sclk};
            sda_sync <= {sda_sync[0], sda_in};
        end
    end

`ifdef I2C_SLAVE_FILTER_EN
    logic [1:0] scl_hist, sda_hist;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
        end
    end

    // A level must be seen in two of the last three samples, so single-cycle pulses vanish.
    assign scl_f = maj3(scl_sync[1], scl_hist[0], scl_hist[1]);
    assign sda_f = maj3(sda_sync[1], sda_hist[0], sda_hist[1]);
`else
    assign scl_f = scl_sync[1];
    assign sda_f = sda_sync[1];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    logic scl_rise, scl_fall, start_ev, stop_ev;
    assign scl_rise = scl_f & ~scl_d;
    assign scl_fall = ~scl_f & scl_d;
    assign start_ev = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_ev  = scl_f & scl_d & ~sda_d & sda_f;

    logic [7:0] shift_q, shift_n, rx_data_q, rx_data_n;
    logic [2:0] cnt_q, cnt_n;
    logic       done_q, done_n, rw_q, rw_n, mack_q, mack_n;
    logic       sda_q, sda_n, busy_q, busy_n, rx_valid_n;

    always_comb begin
        nxt_st     = cur_st;
        shift_n    = shift_q;
        cnt_n      = cnt_q;
        done_n     = done_q;
        rw_n       = rw_q;
        mack_n     = mack_q;
        sda_n      = sda_q;
        busy_n     = busy_q;
        rx_data_n  = rx_data_q;
        rx_valid_n = 1'b0;
        tx_req     = 1'b0;
        if (stop_ev) begin
            nxt_st = IDLE;
            sda_n  = 1'b1;
            busy_n = 1'b0;
        end else if (start_ev) begin
            nxt_st = ADDR;
            cnt_n  = 3'd0;
            done_n = 1'b0;
            sda_n  = 1'b1;
        end else begin
            case (cur_st)
                IDLE: ;
                ADDR, RX: begin
                    if (scl_rise) begin
                        shift_n = {shift_q[6:0], sda_f};
                        cnt_n   = cnt_q + 3'd1;
                        done_n  = (cnt_q == 3'd7);
                    end else if (scl_fall && done_q) begin
                        done_n = 1'b0;
                        if (cur_st == RX) begin
                            rx_data_n  = shift_q;
                            rx_valid_n = 1'b1;
                            sda_n      = 1'b0;
                            nxt_st     = RX_ACK;
                        end else if (shift_q[7:1] == SLAVE_ADDR) begin
                            sda_n  = 1'b0;
                            busy_n = 1'b1;
                            rw_n   = shift_q[0];
                            nxt_st = ADDR_ACK;
                        end else begin
                            sda_n  = 1'b1;
                            busy_n = 1'b0;
                            nxt_st = IDLE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_n  = 3'd0;
                        done_n = 1'b0;
                        if (rw_q) begin
                            tx_req  = 1'b1;
                            shift_n = tx_data;
                            sda_n   = tx_data[7];
                            nxt_st  = TX;
                        end else begin
                            sda_n  = 1'b1;
                            nxt_st = RX;
                        end
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        sda_n  = 1'b1;
                        nxt_st = RX;
                    end
                end
                TX: begin
                    // The fall after bit 0 has been on the wire for a full period hands SDA back.
                    if (scl_fall) begin
                        if (cnt_q == 3'd7) begin
                            sda_n  = 1'b1;
                            cnt_n  = 3'd0;
                            nxt_st = TX_ACK;
                        end else begin
                            shift_n = {shift_q[6:0], 1'b0};
                            sda_n   = shift_q[6];
                            cnt_n   = cnt_q + 3'd1;
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        mack_n = sda_f;
                    end else if (scl_fall) begin
                        if (mack_q) begin
                            sda_n  = 1'b1;
                            busy_n = 1'b0;
                            nxt_st = IDLE;
                        end else begin
                            tx_req  = 1'b1;
                            shift_n = tx_data;
                            sda_n   = tx_data[7];
                            cnt_n   = 3'd0;
                            nxt_st  = TX;
                        end
                    end
                end
                default: nxt_st = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_st <= IDLE;
        end else begin
            cur_st <= nxt_st;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q   <= 8'h00;
            cnt_q     <= 3'd0;
            done_q    <= 1'b0;
            rw_q      <= 1'b0;
            mack_q    <= 1'b1;
            sda_q     <= 1'b1;
            busy_q    <= 1'b0;
            rx_data_q <= 8'h00;
            rx_valid  <= 1'b0;
        end else begin
            shift_q   <= shift_n;
            cnt_q     <= cnt_n;
            done_q    <= done_n;
            rw_q      <= rw_n;
            mack_q    <= mack_n;
            sda_q     <= sda_n;
            busy_q    <= busy_n;
            rx_data_q <= rx_data_n;
            rx_valid  <= rx_valid_n;
        end
    end

    assign sda_out = sda_q;
    assign busy    = busy_q;
    assign rx_data = rx_data_q;
    assign state   = cur_st;

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - self-checking bench for i2c_slave driving a bit-banged I2C master.
`timescale 1ns/1ps
module tb_i2c_slave;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_out, tx_req, rx_valid, busy;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic [2:0] state;
    wire        sda_bus = sda_m & sda_out;

    i2c_slave dut (
        .clk     (clk),
        .rst     (rst),
        .sclk    (scl_m),
        .sda_in  (sda_bus),
        .sda_out (sda_out),
        .tx_data (tx_data),
        .tx_req  (tx_req),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .busy    (busy),
        .state   (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int rx_cnt = 0;
    int tx_cnt = 0;
    int low_cnt = 0;
    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_tx_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (!sda_out) low_cnt++;
            if (tx_req) tx_cnt++;
            if (rx_valid) begin
                rx_cnt++;
                if (exp_rx_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_unexpected: got %0h expected none", rx_data);
                end else begin
                    chk("rx_data", rx_data, exp_rx_q.pop_front());
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask
    task automatic i2c_start();
        sda_m = 1'b1; wq(); scl_m = 1'b1; wq(); sda_m = 1'b0; wq(); scl_m = 1'b0; wq();
    endtask
    task automatic i2c_stop();
        sda_m = 1'b0; wq(); scl_m = 1'b1; wq(); sda_m = 1'b1; wq();
    endtask
    task automatic write_bit(input logic b);
        sda_m = b; wq(); scl_m = 1'b1; wq(); wq(); scl_m = 1'b0; wq();
    endtask
    task automatic read_bit(output logic b);
        sda_m = 1'b1; wq(); scl_m = 1'b1; wq(); b = sda_bus; wq(); scl_m = 1'b0; wq();
    endtask
    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask
    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(ack);
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       addr_ack;
        logic       data_ack;
    } wr_vec_t;

    wr_vec_t    vecs[6];
    logic       a;
    logic [7:0] d, last_rx;
    int         rx0, tx0, low0;

    initial begin
        vecs[0] = '{8'h5a, 8'ha5, 1'b0, 1'b0};
        vecs[1] = '{8'h58, 8'h3c, 1'b1, 1'b1};
        vecs[2] = '{8'h5a, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'h5a, 8'hff, 1'b0, 1'b0};
        vecs[4] = '{8'h5c, 8'h81, 1'b1, 1'b1};
        vecs[5] = '{8'h5a, 8'h81, 1'b0, 1'b0};
        last_rx = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_sda_out", sda_out, 1'b1);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_tx_req", tx_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_state", state, 3'd0);
        rst = 1'b1;
        wq();

        for (int i = 0; i < 6; i++) begin
            rx0 = rx_cnt;
            low0 = low_cnt;
            i2c_start();
            write_byte(vecs[i].addr, a);
            chk("addr_ack", a, vecs[i].addr_ack);
            chk("busy_after_addr", busy, !vecs[i].addr_ack);
            if (!vecs[i].addr_ack) begin
                exp_rx_q.push_back(vecs[i].data);
                last_rx = vecs[i].data;
            end
            write_byte(vecs[i].data, a);
            chk("data_ack", a, vecs[i].data_ack);
            i2c_stop();
            wq();
            chk("busy_after_stop", busy, 1'b0);
            chk("state_after_stop", state, 3'd0);
            chk("rx_valid_count", rx_cnt - rx0, {31'd0, !vecs[i].addr_ack});
            chk("rx_data_held", rx_data, last_rx);
            if (vecs[i].addr_ack) chk("no_sda_drive", low_cnt - low0, 0);
        end

        // Single-byte read, NACKed by the master.
        tx0 = tx_cnt;
        tx_data = 8'h3c;
        exp_tx_q.push_back(8'h3c);
        i2c_start();
        write_byte(8'h5b, a);
        chk("rd_addr_ack", a, 1'b0);
        chk("rd_busy", busy, 1'b1);
        read_byte(d, 1'b1);
        chk("rd_byte", d, exp_tx_q.pop_front());
        chk("rd_state_after_nack", state, 3'd0);
        chk("rd_busy_after_nack", busy, 1'b0);
        chk("rd_tx_req_count", tx_cnt - tx0, 1);
        i2c_stop();

        // Two-byte read; tx_data changes once the first byte has been captured.
        tx0 = tx_cnt;
        tx_data = 8'h3c;
        i2c_start();
        write_byte(8'h5b, a);
        chk("rd2_addr_ack", a, 1'b0);
        exp_tx_q.push_back(8'h3c);
        tx_data = 8'hc3;
        exp_tx_q.push_back(8'hc3);
        read_byte(d, 1'b0);
        chk("rd2_byte0", d, exp_tx_q.pop_front());
        read_byte(d, 1'b1);
        chk("rd2_byte1", d, exp_tx_q.pop_front());
        chk("rd2_tx_req_count", tx_cnt - tx0, 2);
        i2c_stop();

        // STOP after 4 data bits discards the partial byte.
        rx0 = rx_cnt;
        i2c_start();
        write_byte(8'h5a, a);
        chk("part_addr_ack", a, 1'b0);
        for (int i = 0; i < 4; i++) write_bit(i[0]);
        i2c_stop();
        wq();
        chk("part_no_rx_valid", rx_cnt - rx0, 0);
        chk("part_rx_data", rx_data, last_rx);
        chk("part_state", state, 3'd0);
        i2c_start();
        write_byte(8'h5a, a);
        chk("part_readdr_ack", a, 1'b0);
        exp_rx_q.push_back(8'h42);
        last_rx = 8'h42;
        write_byte(8'h42, a);
        chk("part_data_ack", a, 1'b0);
        i2c_stop();

        // Repeated START mid-byte re-enters address phase with busy held.
        rx0 = rx_cnt;
        i2c_start();
        write_byte(8'h5a, a);
        for (int i = 0; i < 3; i++) write_bit(1'b1);
        i2c_start();
        chk("rs_busy_held", busy, 1'b1);
        chk("rs_state_addr", state, 3'd1);
        write_byte(8'h5a, a);
        chk("rs_addr_ack", a, 1'b0);
        exp_rx_q.push_back(8'h99);
        last_rx = 8'h99;
        write_byte(8'h99, a);
        i2c_stop();
        wq();
        chk("rs_rx_count", rx_cnt - rx0, 1);

        // Reset in the middle of a read while the slave drives SDA low.
        tx_data = 8'h3c;
        i2c_start();
        write_byte(8'h5b, a);
        read_bit(a);
        chk("mid_rd_bit7", a, 1'b0);
        chk("mid_rd_sda_driven", sda_out, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_sda_out", sda_out, 1'b1);
        chk("mid_rst_state", state, 3'd0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rx_data", rx_data, 8'h00);
        last_rx = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        wq();
        i2c_start();
        write_byte(8'h5a, a);
        chk("post_rst_addr_ack", a, 1'b0);
        exp_rx_q.push_back(8'h77);
        last_rx = 8'h77;
        write_byte(8'h77, a);
        chk("post_rst_data_ack", a, 1'b0);
        i2c_stop();
        wq();
        chk("post_rst_rx_data", rx_data, last_rx);

`ifdef I2C_SLAVE_FILTER_EN
        // One-clock SCL glitches while SCL is low must not shift extra bits.
        i2c_start();
        write_byte(8'h5a, a);
        exp_rx_q.push_back(8'h6b);
        last_rx = 8'h6b;
        for (int i = 7; i >= 0; i--) begin
            d = 8'h6b;
            sda_m = d[i];
            wq();
            @(negedge clk) scl_m = 1'b1;
            @(negedge clk) scl_m = 1'b0;
            wq();
            scl_m = 1'b1; wq(); wq(); scl_m = 1'b0; wq();
        end
        read_bit(a);
        chk("glitch_data_ack", a, 1'b0);
        i2c_stop();
        wq();
        chk("glitch_rx_data", rx_data, last_rx);
`endif

        chk("scoreboard_empty", exp_rx_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
